// File: rtl/delay_scheduler_pkg.sv
// Shared definitions for the delay scheduler: FSM encodings, default sizes
// and the round-robin pointer advance helper.
package delay_sched_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int N_REQ_DEF  = 4;
  localparam int UNIT_W_DEF = 8;
  localparam int ID_W_DEF   = 2;

  // Pointer position just past the requester that was served, wrapping at n.
  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/delay_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping around. Returns the winner as one-hot and as an index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] winner,
  output logic [ID_W-1:0]  win_id,
  output logic             found
);

  // Scan N_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    winner = '0;
    win_id = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_id      = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// Shares one run/reached interval timer between N_REQ requesters. Each winner
// gets units[w] timer intervals, then a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grantee; arbitrate pending requests
// RUN   | timer_run=1, waiting for timer_reached
// GAP   | timer_run=0 for one cycle to clear the timer; the first cycle of
//       | every grant is also a GAP, so each service starts from a clean timer
// DONE  | done pulse to the grantee, grant already dropped
module delay_scheduler
  import delay_sched_defs::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int UNIT_W = UNIT_W_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic                      tick,
  input  logic                      clear,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*UNIT_W-1:0]   units,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic                      timer_run,
  input  logic                      timer_reached,
  output logic                      busy,
  output logic [ID_W-1:0]           active_id
);

  state_t              state, state_nx;
  logic [ID_W-1:0]     win_q;
  logic [ID_W-1:0]     ptr_q;
  logic [UNIT_W-1:0]   units_q;
  logic [UNIT_W-1:0]   cnt_q;
  logic [UNIT_W-1:0]   cnt_inc;
  logic [N_REQ-1:0]    arb_oh;
  logic [ID_W-1:0]     arb_id;
  logic                arb_found;
  logic                req_w;
  logic                last_unit;
  logic                release_w;
  logic [N_REQ-1:0]    win_oh;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (arb_oh),
    .win_id (arb_id),
    .found  (arb_found)
  );

  assign req_w     = req[win_q];
  assign cnt_inc   = cnt_q + {{(UNIT_W-1){1'b0}}, 1'b1};
  assign last_unit = (cnt_inc == units_q);
  assign win_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;

  // Next state; an abort (grantee drops req) beats a reached in the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (arb_found) state_nx = ST_GAP;
      ST_RUN: begin
        if (!req_w)             state_nx = ST_IDLE;
        else if (timer_reached) state_nx = last_unit ? ST_DONE : ST_GAP;
      end
      ST_GAP: begin
        if (!req_w)                 state_nx = ST_IDLE;
        else if (units_q == '0)     state_nx = ST_DONE;
        else                        state_nx = ST_RUN;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Leaving service by completion or by abort both advance the pointer.
  assign release_w = (state != ST_IDLE) && (state_nx == ST_IDLE);

  // State register, grantee latches, interval counter and rr pointer.
  always_ff @(posedge tick) begin
    if (clear) begin
      state   <= ST_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      units_q <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && arb_found) begin
        win_q   <= arb_id;
        units_q <= units[int'(arb_id)*UNIT_W +: UNIT_W];
        cnt_q   <= '0;
      end
      if (state == ST_RUN && req_w && timer_reached && !last_unit)
        cnt_q <= cnt_inc;
      if (release_w)
        ptr_q <= ID_W'(rr_next(int'(win_q), N_REQ));
    end
  end

  // Outputs are pure decodes of registered state, so they are glitch-free.
  always_comb begin
    grant     = (state == ST_RUN || state == ST_GAP) ? win_oh : '0;
    done      = (state == ST_DONE) ? win_oh : '0;
    timer_run = (state == ST_RUN);
    busy      = (state != ST_IDLE);
    active_id = (state == ST_IDLE) ? '0 : win_q;
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// Directed bench for delay_scheduler with a behavioural 3-cycle interval timer.
module tb_delay_scheduler;

  logic        tick = 1'b0;
  logic        clear;
  logic [3:0]  req;
  logic [31:0] units;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        timer_run;
  logic        timer_reached;
  logic        busy;
  logic [1:0]  active_id;

  logic [1:0]  tcnt;
  logic        force_all;
  logic        force_gap;

  int n_chk = 0;
  int n_err = 0;

  int          runs;
  logic [7:0]  pat;
  logic [3:0]  dn;
  logic [3:0]  gnt;

  always #5 tick = ~tick;

  delay_scheduler #(.N_REQ(4), .UNIT_W(8), .ID_W(2)) dut (
    .tick          (tick),
    .clear         (clear),
    .req           (req),
    .units         (units),
    .grant         (grant),
    .done          (done),
    .timer_run     (timer_run),
    .timer_reached (timer_reached),
    .busy          (busy),
    .active_id     (active_id)
  );

  // Timer model: reached in the third consecutive cycle of run, cleared by run=0.
  always @(posedge tick) begin
    if (!timer_run)         tcnt <= 2'd0;
    else if (tcnt != 2'd3)  tcnt <= tcnt + 2'd1;
  end

  assign timer_reached = (timer_run && tcnt == 2'd2) || force_all ||
                         (force_gap && busy && !timer_run);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge tick);
    #1;
  endtask

  task automatic do_reset;
    clear = 1'b1;
    req   = 4'b0;
    step;
    step;
    clear = 1'b0;
  endtask

  // Step until a done pulse appears or the budget runs out, logging timer_run.
  task automatic run_until_done(input int max, output int r, output logic [7:0] p,
                                output logic [3:0] d, output logic [3:0] g);
    r = 0;
    p = 8'h0;
    d = 4'h0;
    g = 4'hf;
    for (int i = 0; i < max; i++) begin
      step;
      p = {p[6:0], timer_run};
      if (timer_run) r++;
      if (done != 4'h0) begin
        d = done;
        g = grant;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear     = 1'b1;
    req       = 4'b0;
    units     = 32'h0;
    force_all = 1'b0;
    force_gap = 1'b0;
    do_reset;

    chk("rst_grant", grant, 4'b0);
    chk("rst_done", done, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_run", timer_run, 1'b0);
    chk("rst_id", active_id, 2'd0);

    // Single request, two intervals.
    units[15:8] = 8'd2;
    req = 4'b0010;
    step;
    chk("t1_grant", grant, 4'b0010);
    chk("t1_id", active_id, 2'd1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_run0", timer_run, 1'b0);
    run_until_done(40, runs, pat, dn, gnt);
    chk("t1_done", dn, 4'b0010);
    chk("t1_grant_at_done", gnt, 4'b0);
    chk("t1_runs", runs, 6);
    chk("t1_pattern", pat, 8'b11101110);
    req = 4'b0;
    step;
    chk("t1_done_once", done, 4'b0);
    chk("t1_idle", busy, 1'b0);

    // Zero units: grant cycle then done, timer never runs.
    units = 32'h0;
    req = 4'b1000;
    step;
    chk("t2_grant", grant, 4'b1000);
    chk("t2_run_a", timer_run, 1'b0);
    chk("t2_nodone", done, 4'b0);
    step;
    chk("t2_done", done, 4'b1000);
    chk("t2_grant_off", grant, 4'b0);
    chk("t2_run_b", timer_run, 1'b0);
    req = 4'b0;
    step;
    chk("t2_idle", busy, 1'b0);

    // Round-robin over 0,1,3, then 0 beats a re-requesting 3.
    do_reset;
    units = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1011;
    step;
    chk("t3_grant0", grant, 4'b0001);
    run_until_done(40, runs, pat, dn, gnt);
    chk("t3_done0", dn, 4'b0001);
    chk("t3_runs0", runs, 3);
    chk("t3_pat0", pat, 8'b00001110);
    req = 4'b1010;
    step;
    step;
    chk("t3_grant1", grant, 4'b0010);
    chk("t3_id1", active_id, 2'd1);
    run_until_done(40, runs, pat, dn, gnt);
    chk("t3_done1", dn, 4'b0010);
    req = 4'b1000;
    step;
    step;
    chk("t3_grant3", grant, 4'b1000);
    chk("t3_id3", active_id, 2'd3);
    run_until_done(40, runs, pat, dn, gnt);
    chk("t3_done3", dn, 4'b1000);
    req = 4'b1001;
    step;
    step;
    chk("t3_grant0b", grant, 4'b0001);
    req = 4'b0;
    run_until_done(40, runs, pat, dn, gnt);
    chk("t3_abort_nodone", dn, 4'b0);
    chk("t3_idle", busy, 1'b0);

    // Abort during the second RUN interval; pending req[0] follows.
    do_reset;
    units = 32'h0;
    units[23:16] = 8'd5;
    req = 4'b0100;
    step;
    chk("t4_grant", grant, 4'b0100);
    step; step; step; step; step;
    chk("t4_run2", timer_run, 1'b1);
    req = 4'b0001;
    step;
    chk("t4_grant_off", grant, 4'b0);
    chk("t4_run_off", timer_run, 1'b0);
    chk("t4_busy_off", busy, 1'b0);
    chk("t4_nodone", done, 4'b0);
    step;
    chk("t4_grant0", grant, 4'b0001);
    chk("t4_id0", active_id, 2'd0);
    step;
    chk("t4_done0", done, 4'b0001);
    req = 4'b0;
    step;

    // Clear during a GAP, then a full fresh service of 4 intervals.
    do_reset;
    units = 32'h0;
    units[15:8] = 8'd4;
    req = 4'b0010;
    step;
    chk("t5_grant", grant, 4'b0010);
    step; step; step; step;
    chk("t5_in_gap", {busy, timer_run}, 2'b10);
    clear = 1'b1;
    step;
    chk("t5_clr_grant", grant, 4'b0);
    chk("t5_clr_busy", busy, 1'b0);
    chk("t5_clr_run", timer_run, 1'b0);
    chk("t5_clr_id", active_id, 2'd0);
    chk("t5_clr_done", done, 4'b0);
    clear = 1'b0;
    step;
    chk("t5_regrant", grant, 4'b0010);
    run_until_done(80, runs, pat, dn, gnt);
    chk("t5_done", dn, 4'b0010);
    chk("t5_runs", runs, 12);
    req = 4'b0;
    step;

    // timer_reached held high in IDLE and in every GAP must be ignored.
    do_reset;
    units = 32'h0;
    units[7:0] = 8'd2;
    force_all = 1'b1;
    step; step; step;
    chk("t6_idle_busy", busy, 1'b0);
    chk("t6_idle_grant", grant, 4'b0);
    force_all = 1'b0;
    force_gap = 1'b1;
    req = 4'b0001;
    step;
    chk("t6_grant", grant, 4'b0001);
    run_until_done(40, runs, pat, dn, gnt);
    chk("t6_done", dn, 4'b0001);
    chk("t6_runs", runs, 6);
    chk("t6_pattern", pat, 8'b11101110);
    force_gap = 1'b0;
    req = 4'b0;
    step;
    chk("t6_idle_end", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/delay_scheduler.md
Name: delay_scheduler

Overview:
- Shares one interval timer (run/reached style: counts while run=1, clears when run=0, asserts reached at its compare value) between N_REQ requesters.
- Each requester asks for a delay of K timer intervals. The block arbitrates round-robin, sequences run/clear cycles of the timer K times, and pulses done back to the winner.
- Sits between the timer instance and the blink/display sequencers that need millisecond-scale waits.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- UNIT_W, 8, width of each requested interval count.
- ID_W, 2, width of active_id; must satisfy 2**ID_W >= N_REQ.

Ports:
- tick  in  1  system clock.
- clear  in  1  reset; synchronous, active-high.
- req  in  N_REQ  level request per requester; hold until done, or drop to abort.
- units  in  N_REQ*UNIT_W  interval count per requester; requester i at bits [i*UNIT_W +: UNIT_W].
- grant  out  N_REQ  one-hot; high for the whole service of the winner.
- done  out  N_REQ  one-cycle pulse to the winner on completion.
- timer_run  out  1  drives the shared timer's run input.
- timer_reached  in  1  shared timer's reached output.
- busy  out  1  high in any state other than IDLE.
- active_id  out  ID_W  index of the current grantee; 0 when idle.

Behaviour:
- Reset (clear=1 at a tick edge): state=IDLE; grant=0, done=0, timer_run=0, busy=0, active_id=0; rr pointer=0; unit counter=0. This applies mid-operation too. The timer is cleared through timer_run=0.
- States: IDLE, RUN, GAP, DONE.
- IDLE:
  - If any req bit is high, select the first set bit scanning from the rr pointer upward, wrapping.
  - Next cycle: grant[w]=1, active_id=w, busy=1. units[w] is latched into units_q and cnt=0.
  - If units_q would be 0, go to DONE; otherwise go to RUN.
  - Latency from req to grant is 1 cycle.
- RUN:
  - timer_run=1.
  - On timer_reached=1: if cnt+1==units_q go to DONE, else cnt++ and go to GAP.
- GAP:
  - timer_run=0 for exactly 1 cycle, which clears the timer. Then go to RUN.
- DONE:
  - done[w]=1 for 1 cycle and timer_run=0.
  - grant is deasserted in the same cycle done is high. rr pointer=(w+1) mod N_REQ. Next state is IDLE.
- Abort: if req[w] drops while in RUN or GAP, the next state is IDLE.
  - No done pulse; grant, timer_run and busy go to 0.
  - rr pointer=(w+1) mod N_REQ.
- timer_reached is ignored outside RUN.
- units changes after the grant cycle have no effect.
- A requester still holding req in the IDLE cycle after done is treated as a new request. It competes under round-robin and does not get priority.
- Simultaneous requests are resolved purely by the rr pointer. Non-winners wait with no loss of request.
- cnt width is UNIT_W. No wrap is possible because cnt < units_q always.
- The timer's own threshold is fixed by its instance; this block only counts intervals.

Decomposition:
- Shared package/include (delay_sched_defs):
  - state encodings (IDLE=2'd0, RUN=2'd1, GAP=2'd2, DONE=2'd3);
  - default N_REQ/UNIT_W.
- One sub-module, rr_arbiter: combinational priority pick given req and pointer. It outputs a one-hot winner and its index.
- FSM, latches and counter live in delay_scheduler.

Test Plan:
- All scenarios use N_REQ=4, UNIT_W=8, and a behavioural timer model that asserts reached after 3 cycles of continuous run and clears when run=0.
1. Single request: req=4'b0010, units[1]=2 → grant=4'b0010 one cycle later; timer_run high 3 cycles, low 1 (GAP), high 3; done[1] pulses once; busy low after.
2. Zero units: req[3]=1, units[3]=0 → grant[3] for 1 cycle, then done[3] pulse next cycle; timer_run never asserted.
3. Round-robin: req=4'b1011 held, each units=1, each requester drops req after its done → grant order 0,1,3, then 0 again if re-requested; pointer after reset is 0.
4. Abort: req[2]=1, units=5; drop req[2] during the 2nd RUN → next cycle grant=0, timer_run=0, no done; a pending req[0] is granted on the following cycle.
5. Reset mid-run: assert clear during GAP with units=4 → next edge all outputs 0, state IDLE; after release with req still high, a fresh grant with cnt restarting at 0 and the full 4 intervals run.
6. Reached outside RUN: force timer_reached=1 in IDLE and GAP → no state change, no cnt increment.
